regfile_scoreboard: RTL
=======================

// Module: regfile_scoreboard
// PURPOSE
//  Hazard scoreboard and issue controller for the decode stage's register file and CC register.
//  - Counts in-flight writes per architectural register (R0-R7) and for the NZP condition codes.
//  - Stalls decode while any source operand, or the CC, has an outstanding producer.
//  - Sits beside decode; it is updated by decode issue and by writeback (ld_reg_store/ld_cc_store).
// PARAMETERS
//  MAX_INFLIGHT  3  max outstanding writes per register/CC; issue stalls when the target count is at max
//  CNT_W         2  counter width; must satisfy 2**CNT_W > MAX_INFLIGHT
//  WB_BYPASS     1  1: a same-cycle writeback retiring the last producer of a source releases the stall
// PORTS
//  clk            in   1  clock; all state updates on rising edge
//  rst_n          in   1  asynchronous active-low reset
//  id_valid       in   1  decode holds a valid instruction
//  id_src_a       in   3  SR1 index (ir[8:6])
//  id_src_a_used  in   1  instruction reads SR1
//  id_src_b       in   3  SR2/store-source index (regfilemux output)
//  id_src_b_used  in   1  instruction reads SR2
//  id_dest        in   3  destination index (destmux output; R7 for JSR/TRAP)
//  id_wr_reg      in   1  instruction writes the register file
//  id_wr_cc       in   1  instruction sets CC
//  id_rd_cc       in   1  instruction reads CC (BR)
//  ex_ready       in   1  next stage can accept an instruction this cycle
//  wb_valid       in   1  writeback stage retires an instruction
//  wb_dest        in   3  writeback destination index
//  wb_ld_reg      in   1  writeback writes the register file
//  wb_ld_cc       in   1  writeback writes CC
//  flush          in   1  squash all in-flight younger instructions
//  stall          out  1  decode must hold (combinational)
//  issue          out  1  instruction advances to execute this cycle (combinational)
//  pending_mask   out  8  bit i = (count[i] != 0), registered view
//  cc_pending     out  1  CC count != 0
//  sb_error       out  1  sticky: writeback to a register or CC with count 0
// BEHAVIOUR
//  - Reset (async, rst_n=0): all counts=0, cc count=0, sb_error=0; stall=0 and issue=0 while id_valid=0.
//  - Hazards (comb, from current counts):
//    - raw_a  = src_a_used & busy(src_a)
//    - raw_b  = src_b_used & busy(src_b)
//    - raw_cc = rd_cc & busy(cc)
//    - full   = (wr_reg & count[dest]==MAX_INFLIGHT) | (wr_cc & cc_count==MAX_INFLIGHT)
//  - busy(x) = count[x]!=0, except with WB_BYPASS=1: busy(x)=0 when count[x]==1 and a same-cycle wb retires x.
//  - stall = id_valid & (raw_a | raw_b | raw_cc | full | !ex_ready).
//  - issue = id_valid & !stall & !flush.
//  - Count update per edge: next = count + inc - dec.
//    - inc = issue & wr_reg & dest==i.
//    - dec = wb_valid & wb_ld_reg & wb_dest==i & count!=0.
//    - Simultaneous inc and dec on the same register leaves the count unchanged. CC is handled identically.
//  - A writeback that finds count==0 is ignored and sets sb_error (cleared only by reset).
//  - Counts never wrap; saturation is prevented by the full stall.
//  - flush: all counts and cc count go to 0 at the edge; same-cycle issue and wb are ignored.
//    - The pipeline asserts flush only when no surviving older write remains outstanding.
//  - R0 is tracked like any other register (LC-3b R0 is writable).
//  - No internal FSM beyond the counters; the block is one cycle deep and adds no latency to issue.
// STRUCTURE
//  - lc3b_types package: lc3b_reg, lc3b_nzp, and new constant LC3B_NUM_REGS = 8.
//  - Sub-module sb_counter (CNT_W, MAX): inc/dec/clr with async reset and an underflow flag.
//    - 9 instances: R0-R7 and CC.
// TESTING
//  - Reset, then ADD R1<-R2,R3 issues; next cycle ADD R4<-R1,R1 -> stall=1 until wb R1; pending_mask=8'h02 meanwhile.
//  - WB_BYPASS=1: consumer of R1 present in the same cycle as wb R1 (count 1) -> stall=0, issue=1; R1 count ends at 0.
//  - Three back-to-back writers of R5 with no wb -> count 3; a fourth writer stalls (full) until one wb of R5.
//  - Same-cycle issue to R2 and wb of R2 with count=1 -> count stays 1, pending_mask[2]=1.
//  - BR following an ADD (wr_cc) -> stall while cc_pending=1; released on wb_ld_cc.
//  - Spurious wb to R6 with count 0 -> sb_error=1 and sticky; flush mid-stream clears all counts; rst_n low mid-op clears everything immediately.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// Shared LC-3b register-file types used by the decode-stage scoreboard.
package lc3b_types;

    // Architectural register index (R0-R7).
    typedef logic [2:0] lc3b_reg;

    // Condition-code triple (N, Z, P).
    typedef logic [2:0] lc3b_nzp;

    // Number of architectural registers tracked by the scoreboard.
    localparam int LC3B_NUM_REGS = 8;

endpackage

// File: rtl/regfile_scoreboard_counter.sv
// In-flight write counter for one register or for the CC.
// Increments on issue and decrements on writeback.
// It clears on flush and flags a writeback that finds nothing outstanding.
module sb_counter #(
    parameter int CNT_W = 2,
    parameter int MAX   = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX);

    logic dec_eff;

    // A retire only counts against a producer that exists; a flush discards it entirely.
    always_comb begin
        dec_eff   = dec & (count != '0);
        underflow = dec & ~clr & (count == '0);
    end

    // Count update; inc and dec together cancel, and the count never wraps past MAX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec_eff && count != CNT_MAX) begin
            count <= count + CNT_W'(1);
        end else if (!inc && dec_eff) begin
            count <= count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Decode-stage hazard scoreboard for the LC-3b register file and CC.
// It counts outstanding producers per register and stalls decode on RAW hazards or a full counter.
module regfile_scoreboard
    import lc3b_types::*;
#(
    parameter int MAX_INFLIGHT = 3,
    parameter int CNT_W        = 2,
    parameter int WB_BYPASS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [2:0] id_src_a,
    input  logic       id_src_a_used,
    input  logic [2:0] id_src_b,
    input  logic       id_src_b_used,
    input  logic [2:0] id_dest,
    input  logic       id_wr_reg,
    input  logic       id_wr_cc,
    input  logic       id_rd_cc,
    input  logic       ex_ready,
    input  logic       wb_valid,
    input  logic [2:0] wb_dest,
    input  logic       wb_ld_reg,
    input  logic       wb_ld_cc,
    input  logic       flush,
    output logic       stall,
    output logic       issue,
    output logic [7:0] pending_mask,
    output logic       cc_pending,
    output logic       sb_error
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_INFLIGHT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic             BYPASS  = (WB_BYPASS != 0);

    logic [CNT_W-1:0]         reg_count [LC3B_NUM_REGS];
    logic [LC3B_NUM_REGS-1:0] reg_wb_hit;
    logic [LC3B_NUM_REGS-1:0] reg_busy;
    logic [LC3B_NUM_REGS-1:0] reg_inc;
    logic [LC3B_NUM_REGS-1:0] reg_underflow;

    logic [CNT_W-1:0] cc_count;
    logic             cc_wb_hit;
    logic             cc_busy;
    logic             cc_inc;
    logic             cc_underflow;

    logic raw_a;
    logic raw_b;
    logic raw_cc;
    logic full;

    // One counter per architectural register; a retiring last producer is not treated as busy when bypass is on.
    generate
        for (genvar gi = 0; gi < LC3B_NUM_REGS; gi++) begin : g_reg
            assign reg_wb_hit[gi]   = wb_valid & wb_ld_reg & (wb_dest == lc3b_reg'(gi));
            assign reg_busy[gi]     = (reg_count[gi] != '0) &
                                      ~(BYPASS & (reg_count[gi] == CNT_ONE) & reg_wb_hit[gi]);
            assign reg_inc[gi]      = issue & id_wr_reg & (id_dest == lc3b_reg'(gi));
            assign pending_mask[gi] = (reg_count[gi] != '0);

            sb_counter #(
                .CNT_W (CNT_W),
                .MAX   (MAX_INFLIGHT)
            ) u_cnt (
                .clk       (clk),
                .rst_n     (rst_n),
                .clr       (flush),
                .inc       (reg_inc[gi]),
                .dec       (reg_wb_hit[gi]),
                .count     (reg_count[gi]),
                .underflow (reg_underflow[gi])
            );
        end
    endgenerate

    assign cc_wb_hit  = wb_valid & wb_ld_cc;
    assign cc_busy    = (cc_count != '0) & ~(BYPASS & (cc_count == CNT_ONE) & cc_wb_hit);
    assign cc_inc     = issue & id_wr_cc;
    assign cc_pending = (cc_count != '0);

    sb_counter #(
        .CNT_W (CNT_W),
        .MAX   (MAX_INFLIGHT)
    ) u_cc_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (flush),
        .inc       (cc_inc),
        .dec       (cc_wb_hit),
        .count     (cc_count),
        .underflow (cc_underflow)
    );

    // Hazard detection and issue decision from the current counts; no added latency.
    always_comb begin
        raw_a  = id_src_a_used & reg_busy[id_src_a];
        raw_b  = id_src_b_used & reg_busy[id_src_b];
        raw_cc = id_rd_cc & cc_busy;
        full   = (id_wr_reg & (reg_count[id_dest] == CNT_MAX)) |
                 (id_wr_cc & (cc_count == CNT_MAX));
        stall  = id_valid & (raw_a | raw_b | raw_cc | full | ~ex_ready);
        issue  = id_valid & ~stall & ~flush;
    end

    // Sticky error: any writeback that retires a producer that was never issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_error <= 1'b0;
        end else if ((|reg_underflow) | cc_underflow) begin
            sb_error <= 1'b1;
        end
    end

endmodule
